// File: rtl/sparc_pkg.sv
// Shared SPARC encodings, ICC layout and stage state type
// for the execute/memory boundary.
package sparc_pkg;

    localparam logic [1:0] FMT_BR   = 2'b00;
    localparam logic [1:0] FMT_CALL = 2'b01;
    localparam logic [1:0] FMT_ALU  = 2'b10;
    localparam logic [1:0] FMT_MEM  = 2'b11;

    localparam logic [2:0] OP2_BICC = 3'b010;

    localparam logic [5:0] OP3_ADD    = 6'h00;
    localparam logic [5:0] OP3_AND    = 6'h01;
    localparam logic [5:0] OP3_OR     = 6'h02;
    localparam logic [5:0] OP3_SUB    = 6'h04;
    localparam logic [5:0] OP3_ADDCC  = 6'h10;
    localparam logic [5:0] OP3_ANDCC  = 6'h11;
    localparam logic [5:0] OP3_ORCC   = 6'h12;
    localparam logic [5:0] OP3_SUBCC  = 6'h14;
    localparam logic [5:0] MULSCC     = 6'h24;
    localparam logic [5:0] OP3_JMPL   = 6'h38;

    localparam int ICC_C = 0;
    localparam int ICC_V = 1;
    localparam int ICC_Z = 2;
    localparam int ICC_N = 3;

    typedef enum logic {
        RUN,
        ANNUL
    } state_e;

    function automatic logic icc_writes(
        input logic [1:0] op,
        input logic [5:0] op3
    );
        return (op == FMT_ALU) &&
               (op3[5:4] == 2'b01 || op3 == MULSCC);
    endfunction

    function automatic logic y_writes(
        input logic [1:0] op,
        input logic [5:0] op3
    );
        return (op == FMT_ALU) && (op3 == MULSCC);
    endfunction

endpackage

// File: rtl/ex_mem_state_regs.sv
// Architectural ICC and Y registers; written only when the
// stage commits an instruction that targets them.
module ex_mem_state_regs #(
    parameter int         XLEN      = 32,
    parameter logic [3:0] ICC_RESET = 4'b0000,
    parameter logic [XLEN-1:0] Y_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            commit_i,
    input  logic [1:0]      op_i,
    input  logic [5:0]      op3_i,
    input  logic [3:0]      icc_i,
    input  logic [XLEN-1:0] y_i,
    output logic [3:0]      icc_o,
    output logic [XLEN-1:0] y_o
);
    import sparc_pkg::*;

    logic [3:0]      icc_q;
    logic [XLEN-1:0] y_q;
    logic            icc_we;
    logic            y_we;

    assign icc_we = commit_i && icc_writes(op_i, op3_i);
    assign y_we   = commit_i && y_writes(op_i, op3_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            icc_q <= ICC_RESET;
            y_q   <= Y_RESET;
        end else begin
            if (icc_we) icc_q <= icc_i;
            if (y_we)   y_q   <= y_i;
        end
    end

    assign icc_o = icc_q;
    assign y_o   = y_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake,
// fetch redirect pulse and delay-slot annulment.
module ex_mem_stage #(
    parameter int         XLEN      = 32,
    parameter int         RES_W     = 64,
    parameter logic [3:0] ICC_RESET = 4'b0000,
    parameter logic [31:0] Y_RESET  = 32'h0,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid_in,
    output logic             ex_ready_out,
    input  logic [RES_W-1:0] ALU_res_in,
    input  logic [XLEN-1:0]  ALU_target_address_in,
    input  logic             ALU_mux_sel_in,
    input  logic             ALU_a_in,
    input  logic [3:0]       ALU_icc_in,
    input  logic [XLEN-1:0]  ALU_Y_in,
    input  logic [1:0]       op_in,
    input  logic [2:0]       op2_in,
    input  logic [5:0]       op3_in,
    input  logic [4:0]       rd_in,
    input  logic [XLEN-1:0]  store_data_in,
    input  logic [XLEN-1:0]  PC_in,
    input  logic             mem_ready_in,
    output logic             mem_valid_out,
    output logic [RES_W-1:0] mem_res_out,
    output logic [4:0]       mem_rd_out,
    output logic [1:0]       mem_op_out,
    output logic [5:0]       mem_op3_out,
    output logic [XLEN-1:0]  mem_store_data_out,
    output logic [XLEN-1:0]  mem_PC_out,
    output logic [3:0]       icc_out,
    output logic [XLEN-1:0]  Y_out,
    output logic             redirect_valid_out,
    output logic [XLEN-1:0]  redirect_pc_out,
    output logic [CNT_W-1:0] annul_count_out
);
    import sparc_pkg::*;

    state_e           state_q;
    logic             valid_q;
    logic [RES_W-1:0] res_q;
    logic [4:0]       rd_q;
    logic [1:0]       op_q;
    logic [5:0]       op3_q;
    logic [XLEN-1:0]  sd_q;
    logic [XLEN-1:0]  pc_q;
    logic             redir_q;
    logic [XLEN-1:0]  redir_pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept;
    logic stall;
    logic run_acc;
    logic annul_acc;
    logic set_annul;

    assign ex_ready_out = !valid_q || mem_ready_in;
    assign accept       = ex_valid_in && ex_ready_out;
    assign stall        = valid_q && !mem_ready_in;
    assign run_acc      = accept && (state_q == RUN);
    assign annul_acc    = accept && (state_q == ANNUL);
    assign set_annul    = run_acc && (op_in == FMT_BR) &&
                          (op2_in == OP2_BICC) && ALU_a_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            valid_q    <= 1'b0;
            res_q      <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            op3_q      <= '0;
            sd_q       <= '0;
            pc_q       <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            // The pulse is recomputed every cycle, so a stall drops it.
            redir_q <= run_acc && ALU_mux_sel_in;
            if (run_acc && ALU_mux_sel_in)
                redir_pc_q <= ALU_target_address_in;
            if (run_acc) begin
                valid_q <= 1'b1;
                res_q   <= ALU_res_in;
                rd_q    <= rd_in;
                op_q    <= op_in;
                op3_q   <= op3_in;
                sd_q    <= store_data_in;
                pc_q    <= PC_in;
                state_q <= set_annul ? ANNUL : RUN;
            end else if (annul_acc) begin
                valid_q <= 1'b0;
                state_q <= RUN;
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_q <= cnt_q + 1'b1;
            end else if (!stall) begin
                valid_q <= 1'b0;
            end
        end
    end

    ex_mem_state_regs #(
        .XLEN      (XLEN),
        .ICC_RESET (ICC_RESET),
        .Y_RESET   (Y_RESET[XLEN-1:0])
    ) u_state_regs (
        .clk      (clk),
        .reset    (reset),
        .commit_i (run_acc),
        .op_i     (op_in),
        .op3_i    (op3_in),
        .icc_i    (ALU_icc_in),
        .y_i      (ALU_Y_in),
        .icc_o    (icc_out),
        .y_o      (Y_out)
    );

    assign mem_valid_out      = valid_q;
    assign mem_res_out        = res_q;
    assign mem_rd_out         = rd_q;
    assign mem_op_out         = op_q;
    assign mem_op3_out        = op3_q;
    assign mem_store_data_out = sd_q;
    assign mem_PC_out         = pc_q;
    assign redirect_valid_out = redir_q;
    assign redirect_pc_out    = redir_pc_q;
    assign annul_count_out    = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus random bench for ex_mem_stage against a
// transaction-level reference model.
module tb_ex_mem_stage;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid_in;
    logic        ex_ready_out;
    logic [63:0] ALU_res_in;
    logic [31:0] ALU_target_address_in;
    logic        ALU_mux_sel_in;
    logic        ALU_a_in;
    logic [3:0]  ALU_icc_in;
    logic [31:0] ALU_Y_in;
    logic [1:0]  op_in;
    logic [2:0]  op2_in;
    logic [5:0]  op3_in;
    logic [4:0]  rd_in;
    logic [31:0] store_data_in;
    logic [31:0] PC_in;
    logic        mem_ready_in;
    logic        mem_valid_out;
    logic [63:0] mem_res_out;
    logic [4:0]  mem_rd_out;
    logic [1:0]  mem_op_out;
    logic [5:0]  mem_op3_out;
    logic [31:0] mem_store_data_out;
    logic [31:0] mem_PC_out;
    logic [3:0]  icc_out;
    logic [31:0] Y_out;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic [CNT_W-1:0] annul_count_out;

    always #5 clk = ~clk;

    ex_mem_stage #(.CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ex_valid_in           (ex_valid_in),
        .ex_ready_out          (ex_ready_out),
        .ALU_res_in            (ALU_res_in),
        .ALU_target_address_in (ALU_target_address_in),
        .ALU_mux_sel_in        (ALU_mux_sel_in),
        .ALU_a_in              (ALU_a_in),
        .ALU_icc_in            (ALU_icc_in),
        .ALU_Y_in              (ALU_Y_in),
        .op_in                 (op_in),
        .op2_in                (op2_in),
        .op3_in                (op3_in),
        .rd_in                 (rd_in),
        .store_data_in         (store_data_in),
        .PC_in                 (PC_in),
        .mem_ready_in          (mem_ready_in),
        .mem_valid_out         (mem_valid_out),
        .mem_res_out           (mem_res_out),
        .mem_rd_out            (mem_rd_out),
        .mem_op_out            (mem_op_out),
        .mem_op3_out           (mem_op3_out),
        .mem_store_data_out    (mem_store_data_out),
        .mem_PC_out            (mem_PC_out),
        .icc_out               (icc_out),
        .Y_out                 (Y_out),
        .redirect_valid_out    (redirect_valid_out),
        .redirect_pc_out       (redirect_pc_out),
        .annul_count_out       (annul_count_out)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: what the memory stage should see.
    bit          m_valid, m_redir, m_skip_next;
    logic [63:0] m_res;
    logic [4:0]  m_rd;
    logic [1:0]  m_op;
    logic [5:0]  m_op3;
    logic [31:0] m_sd, m_pc, m_y, m_rpc;
    logic [3:0]  m_icc;
    int          m_cnt;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_redir = 0; m_skip_next = 0;
        m_res = 0; m_rd = 0; m_op = 0; m_op3 = 0;
        m_sd = 0; m_pc = 0; m_rpc = 0; m_cnt = 0;
        m_icc = 4'b0000; m_y = 32'h0;
    endtask

    task automatic model_step();
        bit taken, is_cc, is_mulscc;
        taken = ex_valid_in && (!m_valid || mem_ready_in);
        m_redir = 0;
        if (reset) begin
            model_reset();
        end else if (taken && m_skip_next) begin
            m_skip_next = 0;
            m_valid = 0;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (taken) begin
            m_valid = 1;
            m_res = ALU_res_in; m_rd = rd_in;
            m_op = op_in; m_op3 = op3_in;
            m_sd = store_data_in; m_pc = PC_in;
            is_mulscc = (op_in == 2) && (op3_in == 6'h24);
            is_cc = (op_in == 2) && (op3_in >= 6'h10)
                    && (op3_in <= 6'h1f);
            if (is_cc || is_mulscc) m_icc = ALU_icc_in;
            if (is_mulscc) m_y = ALU_Y_in;
            if (ALU_mux_sel_in) begin
                m_redir = 1;
                m_rpc = ALU_target_address_in;
            end
            m_skip_next = (op_in == 0) && (op2_in == 3'b010)
                          && ALU_a_in;
        end else if (mem_ready_in) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        #1;
        if (!reset)
            check("ready", 64'(ex_ready_out),
                  64'(!m_valid || mem_ready_in));
        model_step();
        @(posedge clk);
        #1;
        check("valid", 64'(mem_valid_out), 64'(m_valid));
        check("redir", 64'(redirect_valid_out), 64'(m_redir));
        check("icc", 64'(icc_out), 64'(m_icc));
        check("y", 64'(Y_out), 64'(m_y));
        check("cnt", 64'(annul_count_out), 64'(m_cnt));
        check("rpc", 64'(redirect_pc_out), 64'(m_rpc));
        if (m_valid) begin
            check("res", mem_res_out, m_res);
            check("rd", 64'(mem_rd_out), 64'(m_rd));
            check("op", 64'(mem_op_out), 64'(m_op));
            check("op3", 64'(mem_op3_out), 64'(m_op3));
            check("sd", 64'(mem_store_data_out), 64'(m_sd));
            check("pc", 64'(mem_PC_out), 64'(m_pc));
        end
    endtask

    task automatic idle();
        reset = 0; ex_valid_in = 0; mem_ready_in = 1;
        ALU_res_in = 0; ALU_target_address_in = 0;
        ALU_mux_sel_in = 0; ALU_a_in = 0; ALU_icc_in = 0;
        ALU_Y_in = 0; op_in = 2'b10; op2_in = 0; op3_in = 0;
        rd_in = 0; store_data_in = 0; PC_in = 0;
    endtask

    task automatic alu(input logic [5:0] op3,
                       input logic [3:0] icc,
                       input logic [63:0] res);
        idle();
        ex_valid_in = 1; op_in = 2'b10; op3_in = op3;
        ALU_icc_in = icc; ALU_res_in = res;
        rd_in = 5'd3; PC_in = 32'h100 + 32'(op3);
        store_data_in = 32'hdead_0000 | 32'(op3);
    endtask

    logic [5:0] op3_tab [8] = '{6'h00, 6'h02, 6'h10,
                                6'h12, 6'h14, 6'h24,
                                6'h38, 6'h1f};

    initial begin
        model_reset();
        idle();
        reset = 1;
        tick(); tick();
        check("rst_valid", 64'(mem_valid_out), 64'd0);
        check("rst_icc", 64'(icc_out), 64'd0);
        check("rst_ready", 64'(ex_ready_out), 64'd1);

        alu(6'h14, 4'b0100, 64'd0); tick();
        check("subcc_icc", 64'(icc_out), 64'h4);
        alu(6'h00, 4'b1111, 64'd7); tick();
        check("add_keeps_icc", 64'(icc_out), 64'h4);

        idle(); ex_valid_in = 1; op_in = 2'b00;
        op2_in = 3'b010; ALU_mux_sel_in = 1; ALU_a_in = 1;
        ALU_target_address_in = 32'h0000_1000; tick();
        check("ba_redir", 64'(redirect_valid_out), 64'd1);
        check("ba_pc", 64'(redirect_pc_out), 64'h1000);
        alu(6'h12, 4'b0100, 64'd5); ALU_icc_in = 4'b0001;
        tick();
        check("annul_valid", 64'(mem_valid_out), 64'd0);
        check("annul_redir", 64'(redirect_valid_out), 64'd0);
        check("annul_cnt", 64'(annul_count_out), 64'd1);
        alu(6'h02, 4'b0000, 64'd9); tick();
        check("after_annul", 64'(mem_valid_out), 64'd1);

        alu(6'h10, 4'b0010, 64'd11); mem_ready_in = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", 64'(ex_ready_out), 64'd0);
        end
        mem_ready_in = 1; tick();
        check("released_icc", 64'(icc_out), 64'h2);
        idle(); tick();

        alu(6'h24, 4'b1000, 64'd1);
        ALU_Y_in = 32'h8000_0001; tick();
        check("mulscc_y", 64'(Y_out), 64'h8000_0001);
        check("mulscc_icc", 64'(icc_out), 64'h8);

        idle(); ex_valid_in = 1; op_in = 2'b00;
        op2_in = 3'b010; ALU_mux_sel_in = 1; ALU_a_in = 1;
        ALU_target_address_in = 32'h2000; tick();
        idle(); reset = 1; tick();
        alu(6'h00, 4'b0000, 64'd42); tick();
        check("post_rst_valid", 64'(mem_valid_out), 64'd1);
        check("post_rst_cnt", 64'(annul_count_out), 64'd0);

        // Many annuls in a row drive the narrow counter to saturation.
        for (int i = 0; i < 20; i++) begin
            idle(); ex_valid_in = 1; op_in = 2'b00;
            op2_in = 3'b010; ALU_a_in = 1; tick();
            alu(6'h10, 4'(i), 64'(i)); tick();
        end
        check("sat_cnt", 64'(annul_count_out),
              64'((1 << CNT_W) - 1));

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 60) == 0);
            ex_valid_in = ($urandom_range(0, 3) != 0);
            mem_ready_in = ($urandom_range(0, 3) != 0);
            ALU_res_in = {$urandom, $urandom};
            ALU_target_address_in = $urandom;
            ALU_mux_sel_in = $urandom_range(0, 1);
            ALU_a_in = $urandom_range(0, 1);
            ALU_icc_in = 4'($urandom);
            ALU_Y_in = $urandom;
            op_in = 2'($urandom);
            op2_in = ($urandom_range(0, 1) != 0) ?
                     3'b010 : 3'($urandom);
            op3_in = ($urandom_range(0, 4) != 0) ?
                     op3_tab[$urandom_range(0, 7)] :
                     6'($urandom);
            rd_in = 5'($urandom);
            store_data_in = $urandom;
            PC_in = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
